irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronised sources, edge/level and polarity per channel,
// W1C pending register, masked registered output, single-cycle-ack memory-mapped bus.
module irq_ctrl #(
  parameter int unsigned N_IRQ       = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mem_valid,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic             mem_ready,
  output logic [31:0]      mem_rdata,
  output logic [N_IRQ-1:0] irq_out
);

  typedef enum logic [2:0] {
    REG_PENDING  = 3'd0,
    REG_MASK     = 3'd1,
    REG_MODE     = 3'd2,
    REG_POLARITY = 3'd3,
    REG_RAW      = 3'd4
  } reg_off_e;

  // Bus capture
  logic             r_ready;
  logic [2:0]       r_off;
  logic             r_wr;
  logic [N_IRQ-1:0] r_wdata;
  logic [N_IRQ-1:0] r_bmask;

  logic             w_hit;
  logic             w_accept;
  logic [31:0]      w_lane_mask;
  logic             w_unused_bits;

  // Interrupt state
  logic [N_IRQ-1:0] r_sync [SYNC_STAGES];
  logic [N_IRQ-1:0] r_pend;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] r_mode;
  logic [N_IRQ-1:0] r_pol;
  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] r_irq;

  logic             w_commit;
  logic [N_IRQ-1:0] w_sync;
  logic [N_IRQ-1:0] w_lvl;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_w1c;
  logic [N_IRQ-1:0] w_pend_next;
  logic [N_IRQ-1:0] w_mask_next;
  logic [N_IRQ-1:0] w_mode_next;
  logic [N_IRQ-1:0] w_pol_next;
  logic [N_IRQ-1:0] w_sel;

  assign w_hit       = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
  assign w_accept    = w_hit && !r_ready;
  assign w_lane_mask = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                        {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
  assign w_unused_bits = &{1'b0, mem_addr[1:0], mem_wdata, w_lane_mask};

  // A request held across the ack cycle is accepted again only after ready drops.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_off   <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_bmask <= '0;
    end else begin
      r_ready <= w_accept;
      if (w_accept) begin
        r_off   <= mem_addr[4:2];
        r_wr    <= |mem_wstrb;
        r_wdata <= mem_wdata[N_IRQ-1:0];
        r_bmask <= w_lane_mask[N_IRQ-1:0];
      end
    end
  end

  assign mem_ready = r_ready;
  assign w_commit  = r_ready && r_wr;

  function automatic logic [N_IRQ-1:0] merge_lanes(input logic [N_IRQ-1:0] old_v,
                                                   input logic [N_IRQ-1:0] new_v,
                                                   input logic [N_IRQ-1:0] lanes);
    return (old_v & ~lanes) | (new_v & lanes);
  endfunction

  assign w_mask_next = (w_commit && r_off == REG_MASK)
                     ? merge_lanes(r_mask, r_wdata, r_bmask) : r_mask;
  assign w_mode_next = (w_commit && r_off == REG_MODE)
                     ? merge_lanes(r_mode, r_wdata, r_bmask) : r_mode;
  assign w_pol_next  = (w_commit && r_off == REG_POLARITY)
                     ? merge_lanes(r_pol, r_wdata, r_bmask) : r_pol;
  assign w_w1c       = (w_commit && r_off == REG_PENDING) ? (r_wdata & r_bmask) : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= irq_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_lvl  = w_sync ^ r_pol;
  assign w_rise = w_lvl & ~r_prev;

  // Edge channels: a new rise beats a same-cycle W1C. Level channels track lvl.
  assign w_pend_next = (r_mode & ((r_pend & ~w_w1c) | w_rise)) | (~r_mode & w_lvl);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pend <= '0;
      r_mask <= '0;
      r_mode <= '0;
      r_pol  <= '0;
      r_prev <= '0;
      r_irq  <= '0;
    end else begin
      r_pend <= w_pend_next;
      r_mask <= w_mask_next;
      r_mode <= w_mode_next;
      r_pol  <= w_pol_next;
      // History uses the polarity in force next cycle, so a polarity flip is not an edge.
      r_prev <= w_sync ^ w_pol_next;
      r_irq  <= r_pend & r_mask;
    end
  end

  assign irq_out = r_irq;

  always_comb begin
    w_sel = '0;
    case (r_off)
      REG_PENDING:  w_sel = r_pend;
      REG_MASK:     w_sel = r_mask;
      REG_MODE:     w_sel = r_mode;
      REG_POLARITY: w_sel = r_pol;
      REG_RAW:      w_sel = w_lvl;
      default:      w_sel = '0;
    endcase
    mem_rdata = '0;
    if (r_ready) mem_rdata[N_IRQ-1:0] = w_sel;
  end

endmodule
